// File: rtl/pixel_dispatcher.sv
// Frame pixel dispatcher: hands out pixel coordinates and c values to idle solvers
// round-robin, tracks results in flight and times each frame.
module pixel_dispatcher #(
    parameter int unsigned NUM_SOLVERS = 4,
    parameter int unsigned XSIZE       = 640,
    parameter int unsigned YSIZE       = 480
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic signed [26:0]     x_pos,
    input  logic signed [26:0]     y_pos,
    input  logic signed [26:0]     zoom_x,
    input  logic signed [26:0]     zoom_y,
    input  logic [NUM_SOLVERS-1:0] req,
    input  logic [NUM_SOLVERS-1:0] pix_done,
    output logic [NUM_SOLVERS-1:0] gnt,
    output logic [9:0]             pix_x,
    output logic [8:0]             pix_y,
    output logic signed [26:0]     cre,
    output logic signed [26:0]     cim,
    output logic                   busy,
    output logic                   frame_done,
    output logic [31:0]            cycles,
    output logic                   err
);

    localparam int unsigned PtrW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    localparam logic [9:0] XLast = 10'(XSIZE - 1);
    localparam logic [8:0] YLast = 9'(YSIZE - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(NUM_SOLVERS - 1);

    typedef enum logic [1:0] {StIdle, StDispatch, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [PtrW-1:0]    rr_q, rr_d;
    logic [9:0]         pix_x_q, pix_x_d;
    logic [8:0]         pix_y_q, pix_y_d;
    logic signed [26:0] cre_q, cre_d, cim_q, cim_d;
    logic signed [26:0] x0_q, x0_d, zx_q, zx_d, zy_q, zy_d;
    logic [7:0]         outstanding_q, outstanding_d;
    logic [31:0]        cnt_q, cnt_d, cycles_q, cycles_d;
    logic               err_q, err_d;

    logic               any_gnt;
    logic [PtrW-1:0]    grant_idx;
    logic [PtrW-1:0]    probe_idx;
    logic [4:0]         done_cnt;
    logic [8:0]         out_sum;

    // Round-robin search starting at the solver after the last one granted.
    always_comb begin
        any_gnt   = 1'b0;
        grant_idx = rr_q;
        probe_idx = '0;
        gnt       = '0;
        if (state_q == StDispatch) begin
            for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
                probe_idx = PtrW'((32'(rr_q) + i) % NUM_SOLVERS);
                if (!any_gnt && req[probe_idx]) begin
                    any_gnt   = 1'b1;
                    grant_idx = probe_idx;
                end
            end
            if (any_gnt) begin
                gnt = NUM_SOLVERS'(1) << grant_idx;
            end
        end
    end

    always_comb begin
        done_cnt = '0;
        for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
            done_cnt = done_cnt + 5'(pix_done[i]);
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        cre_d         = cre_q;
        cim_d         = cim_q;
        x0_d          = x0_q;
        zx_d          = zx_q;
        zy_d          = zy_q;
        cnt_d         = cnt_q;
        cycles_d      = cycles_q;
        err_d         = err_q;
        outstanding_d = outstanding_q;

        // Net grant/completion update; a completion with nothing in flight is a protocol error.
        out_sum = {1'b0, outstanding_q} + 9'(any_gnt);
        if (out_sum < 9'(done_cnt)) begin
            outstanding_d = '0;
            err_d         = 1'b1;
        end else begin
            outstanding_d = 8'(out_sum - 9'(done_cnt));
        end

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    x0_d          = x_pos;
                    zx_d          = zoom_x;
                    zy_d          = zoom_y;
                    cre_d         = x_pos;
                    cim_d         = y_pos;
                    pix_x_d       = '0;
                    pix_y_d       = '0;
                    outstanding_d = '0;
                    cnt_d         = '0;
                    state_d       = StDispatch;
                end
            end
            StDispatch: begin
                cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                if (any_gnt) begin
                    rr_d = (grant_idx == PtrLast) ? '0 : grant_idx + 1'b1;
                    if (pix_x_q == XLast && pix_y_q == YLast) begin
                        state_d = StDrain;
                    end else if (pix_x_q == XLast) begin
                        pix_x_d = '0;
                        cre_d   = x0_q;
                        pix_y_d = pix_y_q + 9'd1;
                        cim_d   = cim_q + zy_q;
                    end else begin
                        pix_x_d = pix_x_q + 10'd1;
                        cre_d   = cre_q + zx_q;
                    end
                end
            end
            StDrain: begin
                cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                if (outstanding_d == 8'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                cycles_d = cnt_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            rr_q          <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            cre_q         <= '0;
            cim_q         <= '0;
            x0_q          <= '0;
            zx_q          <= '0;
            zy_q          <= '0;
            outstanding_q <= '0;
            cnt_q         <= '0;
            cycles_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            cre_q         <= cre_d;
            cim_q         <= cim_d;
            x0_q          <= x0_d;
            zx_q          <= zx_d;
            zy_q          <= zy_d;
            outstanding_q <= outstanding_d;
            cnt_q         <= cnt_d;
            cycles_q      <= cycles_d;
            err_q         <= err_d;
        end
    end

    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign cre        = cre_q;
    assign cim        = cim_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);
    assign cycles     = cycles_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Scoreboard bench for pixel_dispatcher on a 4x2 frame with four solvers.
module tb_pixel_dispatcher;

    localparam int ONE = 1 << 23;

    typedef struct packed {
        logic [3:0]  g;
        logic [9:0]  px;
        logic [8:0]  py;
        logic [26:0] cr;
        logic [26:0] ci;
    } grant_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [26:0] x_pos, y_pos, zoom_x, zoom_y;
    logic [3:0]  req, pix_done, gnt;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [26:0] cre, cim;
    logic        busy, frame_done, err;
    logic [31:0] cycles;

    int tests = 0;
    int fails = 0;
    int fd_count = 0;
    grant_t exp_q[$];
    grant_t mon_a, mon_e;

    pixel_dispatcher #(
        .NUM_SOLVERS(4),
        .XSIZE      (4),
        .YSIZE      (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .zoom_x     (zoom_x),
        .zoom_y     (zoom_y),
        .req        (req),
        .pix_done   (pix_done),
        .gnt        (gnt),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .cre        (cre),
        .cim        (cim),
        .busy       (busy),
        .frame_done (frame_done),
        .cycles     (cycles),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] fx(input int v);
        return v[26:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input int px, input int py, input int cr,
                        input int ci);
        grant_t e;
        e.g  = g;
        e.px = 10'(px);
        e.py = 9'(py);
        e.cr = fx(cr);
        e.ci = fx(ci);
        exp_q.push_back(e);
    endtask

    // Monitor: every grant seen must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && gnt !== 4'b0000) begin
            tests++;
            mon_a = '{g: gnt, px: pix_x, py: pix_y, cr: cre, ci: cim};
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected grant: got %h, want none", mon_a);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    fails++;
                    $display("FAIL grant: got %h, want %h", mon_a, mon_e);
                end
            end
        end
        if (!rst && frame_done === 1'b1) fd_count++;
    end

    // All solvers requesting; each grant is answered by pix_done three cycles later.
    task automatic run_frame(input int x, input int y, input int zx, input int zy,
                             output logic seen, output int fd_c, output int last_c);
        logic [3:0] pipe [3];
        logic [3:0] g;
        seen   = 1'b0;
        fd_c   = -1;
        last_c = -1;
        for (int i = 0; i < 3; i++) pipe[i] = 4'b0;
        x_pos       = fx(x);
        y_pos       = fx(y);
        zoom_x      = fx(zx);
        zoom_y      = fx(zy);
        frame_start = 1'b1;
        req         = 4'hF;
        pix_done    = 4'b0;
        tick();
        frame_start = 1'b0;
        x_pos       = 27'h5A5A5A5;
        y_pos       = 27'h1234567;
        zoom_x      = 27'h7FFFFFF;
        zoom_y      = 27'h0000001;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            g = gnt;
            if (pix_done != 4'b0) last_c = c;
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                fd_c = c;
            end
            @(posedge clk);
            #1;
            pipe[2]  = pipe[1];
            pipe[1]  = pipe[0];
            pipe[0]  = g;
            pix_done = pipe[2];
        end
        pix_done = 4'b0;
        req      = 4'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        int   fd_c, last_c, fd_before;

        rst = 1'b1;
        frame_start = 1'b0;
        x_pos = '0; y_pos = '0; zoom_x = '0; zoom_y = '0;
        req = 4'hF;
        pix_done = 4'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state (req held high: IDLE must not grant)
        check("rst gnt", 64'(gnt), 64'h0);
        check("rst busy", 64'(busy), 64'h0);
        check("rst frame_done", 64'(frame_done), 64'h0);
        check("rst err", 64'(err), 64'h0);
        check("rst cycles", 64'(cycles), 64'h0);
        check("rst pix", 64'({pix_x, pix_y}), 64'h0);
        check("rst c", 64'({cre, cim}), 64'h0);
        check("rst outstanding", 64'(dut.outstanding_q), 64'h0);
        req = 4'b0;

        // Frame A: round-robin and row wrap, 8 pixels
        for (int k = 0; k < 8; k++) begin
            int cr_tab [4];
            cr_tab = '{-2 * ONE, -3 * ONE / 2, -ONE, -ONE / 2};
            push(4'b0001 << (k % 4), k % 4, k / 4, cr_tab[k % 4], (k < 4) ? ONE : ONE / 2);
        end
        run_frame(-2 * ONE, ONE, ONE / 2, -ONE / 2, seen, fd_c, last_c);
        check("A frame_done seen", 64'(seen), 64'h1);
        check("A frame_done latency", 64'(fd_c - last_c), 64'h1);
        check("A cycles", 64'(cycles), 64'd11);
        check("A back to idle", 64'({busy, frame_done}), 64'h0);
        check("A grants consumed", 64'(exp_q.size()), 64'h0);
        check("A done pulses", 64'(fd_count), 64'h1);
        check("A err clear", 64'(err), 64'h0);

        // Frame B: wrap-around arithmetic, ignored frame_start, net outstanding update
        fd_before   = fd_count;
        x_pos       = fx(7 * ONE);
        y_pos       = fx(0);
        zoom_x      = fx(ONE);
        zoom_y      = fx(ONE);
        frame_start = 1'b1;
        tick();
        x_pos  = fx(-5 * ONE);
        zoom_x = fx(3);
        req    = 4'b0001;
        push(4'b0001, 0, 0, 7 * ONE, 0);
        push(4'b0001, 1, 0, -8 * ONE, 0);
        push(4'b0001, 2, 0, -7 * ONE, 0);
        push(4'b0001, 3, 0, -6 * ONE, 0);
        tick();
        tick();
        tick();
        check("B outstanding 3", 64'(dut.outstanding_q), 64'd3);
        pix_done = 4'b0011;
        tick();
        pix_done    = 4'b0;
        req         = 4'b0;
        frame_start = 1'b0;
        check("B grant+2 done", 64'(dut.outstanding_q), 64'd2);
        check("B busy", 64'(busy), 64'h1);
        tick();
        check("B no req no gnt", 64'(gnt), 64'h0);
        check("B row wrap pix", 64'({pix_x, pix_y}), 64'({10'd0, 9'd1}));
        check("B row wrap c", 64'({cre, cim}), 64'({fx(7 * ONE), fx(ONE)}));
        check("B grants consumed", 64'(exp_q.size()), 64'h0);

        // Mid-frame reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'hF;
        check("mid rst busy", 64'(busy), 64'h0);
        check("mid rst gnt", 64'(gnt), 64'h0);
        check("mid rst cycles", 64'(cycles), 64'h0);
        check("mid rst pix", 64'({pix_x, pix_y, cre, cim}), 64'h0);
        check("mid rst outstanding", 64'(dut.outstanding_q), 64'h0);
        req = 4'b0;
        tick();
        check("mid rst no done", 64'(fd_count - fd_before), 64'h0);

        // Protocol error in IDLE
        pix_done = 4'b0001;
        tick();
        pix_done = 4'b0;
        check("err set", 64'(err), 64'h1);
        check("err outstanding clamp", 64'(dut.outstanding_q), 64'h0);
        tick();
        tick();
        check("err sticky", 64'(err), 64'h1);

        // Frame C: restarts at (0,0) with pointer back at solver 0
        for (int k = 0; k < 8; k++) begin
            int cr_tab [4];
            cr_tab = '{-ONE, -3 * ONE / 4, -ONE / 2, -ONE / 4};
            push(4'b0001 << (k % 4), k % 4, k / 4, cr_tab[k % 4],
                 (k < 4) ? 2 * ONE : 2 * ONE + ONE / 8);
        end
        fd_before = fd_count;
        run_frame(-ONE, 2 * ONE, ONE / 4, ONE / 8, seen, fd_c, last_c);
        check("C frame_done seen", 64'(seen), 64'h1);
        check("C frame_done latency", 64'(fd_c - last_c), 64'h1);
        check("C cycles", 64'(cycles), 64'd11);
        check("C one pulse", 64'(fd_count - fd_before), 64'h1);
        check("C grants consumed", 64'(exp_q.size()), 64'h0);
        check("C err still sticky", 64'(err), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
